// File: rtl/obstacle_engine_if.sv
// Control/status bundle between the game controller, obstacle_engine and the renderer.
// Slot i occupies bits [8i+7:8i] of obs_x/obs_h.
interface obstacle_engine_if #(
  parameter int unsigned NUM_OBS = 4
) ();
  logic                   clear;
  logic                   run;
  logic                   frame_tick;
  logic [2:0]             speed;
  logic [7:0]             dino_y;
  logic [8*NUM_OBS-1:0]   obs_x;
  logic [8*NUM_OBS-1:0]   obs_h;
  logic [NUM_OBS-1:0]     obs_active;
  logic [NUM_OBS-1:0]     obs_air;
  logic                   collision;
  logic [3:0]             pass_count;

  modport master (
    output clear, run, frame_tick, speed, dino_y,
    input  obs_x, obs_h, obs_active, obs_air, collision, pass_count
  );

  modport slave (
    input  clear, run, frame_tick, speed, dino_y,
    output obs_x, obs_h, obs_active, obs_air, collision, pass_count
  );
endinterface

// File: rtl/obstacle_engine.sv
// Multi-slot obstacle scroller/spawner with dino overlap detection and pass counting.
// Define OBS_AIR_EN to allow airborne obstacles lifted AIR_LIFT px above the ground line.
module obstacle_engine #(
  parameter int unsigned NUM_OBS    = 4,
  parameter int unsigned SPAWN_X    = 160,
  parameter int unsigned OBS_W      = 12,
  parameter int unsigned MIN_H      = 7,
  parameter int unsigned MAX_H      = 14,
  parameter int unsigned MIN_GAP    = 40,
  parameter int unsigned DINO_L     = 15,
  parameter int unsigned DINO_R     = 25,
  parameter int unsigned DINO_H     = 12,
  parameter int unsigned GROUND_TOP = 105,
  parameter int unsigned AIR_LIFT   = 14,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic              clk,
  input logic              reset,
  obstacle_engine_if.slave bus
);

  localparam logic [7:0]  SpawnX    = 8'(SPAWN_X);
  localparam logic [7:0]  MinH      = 8'(MIN_H);
  localparam logic [7:0]  MaxH      = 8'(MAX_H);
  localparam logic [7:0]  MinGap    = 8'(MIN_GAP);
  localparam logic [8:0]  ObsW      = 9'(OBS_W);
  localparam logic [8:0]  DinoL     = 9'(DINO_L);
  localparam logic [7:0]  DinoR     = 8'(DINO_R);
  localparam logic [8:0]  DinoH     = 9'(DINO_H);
  localparam logic [7:0]  GroundTop = 8'(GROUND_TOP);
  localparam logic [7:0]  AirBottom = 8'(GROUND_TOP - AIR_LIFT);
  localparam logic [15:0] LfsrMask  = 16'hB400;

  logic [7:0]         x_q   [NUM_OBS];
  logic [7:0]         x_d   [NUM_OBS];
  logic [7:0]         h_q   [NUM_OBS];
  logic [7:0]         h_d   [NUM_OBS];
  logic [7:0]         slot_top [NUM_OBS];
  logic [7:0]         slot_bot [NUM_OBS];
  logic [NUM_OBS-1:0] active_q, active_d;
  logic [NUM_OBS-1:0] slot_air;
  logic [NUM_OBS-1:0] free_sel;
  logic [7:0]         gap_q, gap_d;
  logic [7:0]         gap_tgt_q, gap_tgt_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               collision_q, collision_d;
  logic [3:0]         pass_q, pass_d;
  logic [3:0]         pass_n;
  logic [7:0]         spd;
  logic [7:0]         h_new;
  logic [8:0]         gap_sum;
  logic               advance;
  logic               found;
  logic               spawn;
  logic               hit;

`ifdef OBS_AIR_EN
  logic [NUM_OBS-1:0] air_q, air_d;
  assign slot_air = air_q;
`else
  assign slot_air = '0;
`endif

  assign advance = bus.frame_tick & bus.run & ~collision_q;
  assign spd     = {5'b0, bus.speed};

  // Slot scrolling, retirement, pass counting and spawning.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);

    // Free slot chosen from pre-tick occupancy so a slot retiring now stays empty this tick.
    free_sel = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      if (!active_q[i] && !found) begin
        free_sel[i] = 1'b1;
        found       = 1'b1;
      end
    end
    spawn = advance && found && (gap_q >= gap_tgt_q);

    h_new = MinH + {5'b0, lfsr_q[2:0]};
    if (h_new > MaxH) h_new = MaxH;

    active_d = active_q;
    pass_n   = 4'd0;
`ifdef OBS_AIR_EN
    air_d = air_q;
`endif
    for (int i = 0; i < NUM_OBS; i++) begin
      x_d[i] = x_q[i];
      h_d[i] = h_q[i];
      if (advance && active_q[i]) begin
        if (x_q[i] < spd) begin
          active_d[i] = 1'b0;
        end else begin
          x_d[i] = x_q[i] - spd;
        end
        if (({1'b0, x_q[i]} + ObsW > DinoL) &&
            ((x_q[i] < spd) || ({1'b0, x_q[i] - spd} + ObsW <= DinoL))) begin
          pass_n = pass_n + 4'd1;
        end
      end
      if (spawn && free_sel[i]) begin
        x_d[i]      = SpawnX;
        h_d[i]      = h_new;
        active_d[i] = 1'b1;
`ifdef OBS_AIR_EN
        air_d[i] = lfsr_q[8];
`endif
      end
    end

    gap_d     = gap_q;
    gap_tgt_d = gap_tgt_q;
    gap_sum   = {1'b0, gap_q} + {1'b0, spd};
    if (spawn) begin
      gap_d     = 8'd0;
      gap_tgt_d = MinGap + {3'b0, lfsr_q[7:3]};
    end else if (advance) begin
      gap_d = gap_sum[8] ? 8'hFF : gap_sum[7:0];
    end

    pass_d = advance ? pass_n : 4'd0;
  end

  // Overlap test runs every cycle on registered slot state.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      slot_bot[i] = slot_air[i] ? AirBottom : GroundTop;
      slot_top[i] = slot_bot[i] - h_q[i];
      if (active_q[i] && (x_q[i] < DinoR) && ({1'b0, x_q[i]} + ObsW > DinoL) &&
          (bus.dino_y < slot_bot[i]) && ({1'b0, bus.dino_y} + DinoH > {1'b0, slot_top[i]})) begin
        hit = 1'b1;
      end
    end
    collision_d = collision_q | hit;
  end

  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        x_q[i] <= SpawnX;
        h_q[i] <= 8'd0;
      end
      active_q    <= '0;
`ifdef OBS_AIR_EN
      air_q       <= '0;
`endif
      gap_q       <= 8'd0;
      gap_tgt_q   <= MinGap;
      lfsr_q      <= LFSR_SEED;
      collision_q <= 1'b0;
      pass_q      <= 4'd0;
    end else begin
      for (int i = 0; i < NUM_OBS; i++) begin
        x_q[i] <= x_d[i];
        h_q[i] <= h_d[i];
      end
      active_q    <= active_d;
`ifdef OBS_AIR_EN
      air_q       <= air_d;
`endif
      gap_q       <= gap_d;
      gap_tgt_q   <= gap_tgt_d;
      lfsr_q      <= lfsr_d;
      collision_q <= collision_d;
      pass_q      <= pass_d;
    end
  end

  always_comb begin
    bus.obs_x = '0;
    bus.obs_h = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      bus.obs_x[8*i +: 8] = x_q[i];
      bus.obs_h[8*i +: 8] = h_q[i];
    end
  end

  assign bus.obs_active = active_q;
  assign bus.obs_air    = slot_air;
  assign bus.collision  = collision_q;
  assign bus.pass_count = pass_q;

endmodule

// File: tb/tb_obstacle_engine.sv
// Scoreboard bench for obstacle_engine: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them. Two instances: 4 slots and 1 slot (SPAWN_X=255).
module tb_obstacle_engine;

  localparam int KX    = 0;
  localparam int KH    = 1;
  localparam int KACT  = 2;  // single active bit
  localparam int KACTV = 3;  // whole active vector
  localparam int KCOL  = 4;
  localparam int KPASS = 5;
  localparam int KAIR  = 6;

  typedef struct {
    int    cyc;
    int    dut;
    int    kind;
    int    idx;
    int    val;
    string name;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] l0, l1;
  logic [15:0] last_l;

  obstacle_engine_if #(.NUM_OBS(4)) if0 ();
  obstacle_engine_if #(.NUM_OBS(1)) if1 ();

  obstacle_engine #(.NUM_OBS(4)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  obstacle_engine #(.NUM_OBS(1), .SPAWN_X(255)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR per instance: Galois, mask B400, seeded on reset/clear.
  always @(posedge clk) begin
    if (reset || if0.clear) l0 <= 16'hACE1;
    else l0 <= {1'b0, l0[15:1]} ^ (l0[0] ? 16'hB400 : 16'h0000);
    if (reset || if1.clear) l1 <= 16'hACE1;
    else l1 <= {1'b0, l1[15:1]} ^ (l1[0] ? 16'hB400 : 16'h0000);
  end

  function automatic int hexp(input logic [15:0] l);
    int h;
    h = 7 + int'(l[2:0]);
    return (h > 14) ? 14 : h;
  endfunction

  function automatic int actual(input int d, input int k, input int i);
    if (d == 0) begin
      case (k)
        KX:      return int'(if0.obs_x[8*i +: 8]);
        KH:      return int'(if0.obs_h[8*i +: 8]);
        KACT:    return int'(if0.obs_active[i]);
        KACTV:   return int'(if0.obs_active);
        KCOL:    return int'(if0.collision);
        KPASS:   return int'(if0.pass_count);
        default: return int'(if0.obs_air);
      endcase
    end else begin
      case (k)
        KX:      return int'(if1.obs_x);
        KH:      return int'(if1.obs_h);
        KACT:    return int'(if1.obs_active);
        KACTV:   return int'(if1.obs_active);
        KCOL:    return int'(if1.collision);
        KPASS:   return int'(if1.pass_count);
        default: return int'(if1.obs_air);
      endcase
    end
  endfunction

  task automatic chk(input int d, input int k, input int i, input int v, input int dc,
                     input string name);
    exp_t e;
    e.cyc  = cyc + dc;
    e.dut  = d;
    e.kind = k;
    e.idx  = i;
    e.val  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: compares every expectation stamped for the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        int a;
        a = actual(sb[i].dut, sb[i].kind, sb[i].idx);
        total++;
        if (a != sb[i].val) begin
          bad++;
          $display("FAIL %s: got %0d expected %0d (cycle %0d)", sb[i].name, a, sb[i].val, cyc);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL %s: never sampled (due cycle %0d)", sb[i].name, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick(input int d, input int spd);
    if (d == 0) begin
      if0.frame_tick = 1'b1;
      if0.speed      = 3'(spd);
      last_l         = l0;
    end else begin
      if1.frame_tick = 1'b1;
      if1.speed      = 3'(spd);
      last_l         = l1;
    end
    @(posedge clk);
    #1;
    if0.frame_tick = 1'b0;
    if1.frame_tick = 1'b0;
  endtask

  task automatic pulse_clear0();
    if0.clear = 1'b1;
    @(posedge clk);
    #1;
    if0.clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    if0.clear = 0; if0.run = 0; if0.frame_tick = 0; if0.speed = 0; if0.dino_y = 0;
    if1.clear = 0; if1.run = 0; if1.frame_tick = 0; if1.speed = 0; if1.dino_y = 0;
    idle(3);
    reset = 1'b0;
    chk(0, KACTV, 0, 0,   0, "rst_active");
    chk(0, KX,    0, 160, 0, "rst_x0");
    chk(0, KX,    3, 160, 0, "rst_x3");
    chk(0, KH,    0, 0,   0, "rst_h0");
    chk(0, KCOL,  0, 0,   0, "rst_collision");
    chk(0, KPASS, 0, 0,   0, "rst_pass");
    chk(0, KAIR,  0, 0,   0, "rst_air");
    chk(1, KX,    0, 255, 0, "rst1_x0");

    // First spawn after MIN_GAP px of scrolling at speed 1.
    if0.run = 1'b1;
    repeat (40) tick(0, 1);
    chk(0, KACTV, 0, 0, 0, "no_spawn_40");
    tick(0, 1);
    chk(0, KACTV, 0, 1,   0, "spawn41_active");
    chk(0, KX,    0, 160, 0, "spawn41_x");
    chk(0, KH,    0, hexp(last_l), 0, "spawn41_h");

    repeat (10) tick(0, 3);
    chk(0, KX, 0, 130, 0, "scroll_130");
    if0.run = 1'b0;
    repeat (5) tick(0, 3);
    chk(0, KX, 0, 130, 0, "run0_hold");
    if0.run = 1'b1;
    repeat (5) tick(0, 0);
    chk(0, KX, 0, 130, 0, "speed0_hold");

    // Walk slot0 across the dino's left edge.
    repeat (18) tick(0, 7);
    chk(0, KX,    0, 4, 0, "x_at_4");
    chk(0, KPASS, 0, 0, 0, "pass_before");
    tick(0, 1);
    chk(0, KX,    0, 3, 0, "x_at_3");
    chk(0, KPASS, 0, 1, 0, "pass_one");
    chk(0, KPASS, 0, 0, 1, "pass_oneshot");
    idle(1);
    tick(0, 1);
    chk(0, KX,    0, 2, 0, "x_at_2");
    chk(0, KPASS, 0, 0, 0, "no_double_pass");
    tick(0, 3);
    chk(0, KACT,  0, 0, 0, "retire_slot0");
    chk(0, KPASS, 0, 0, 0, "retire_no_pass");

    // Ground obstacle reaches the dino while it stands low.
    pulse_clear0();
    chk(0, KACTV, 0, 0, 0, "clear_active");
    if0.dino_y = 8'd93;
    repeat (11) tick(0, 4);
    chk(0, KACTV, 0, 1,   0, "c_spawn_active");
    chk(0, KH,    0, hexp(last_l), 0, "c_spawn_h");
    repeat (33) tick(0, 4);
    chk(0, KX,   0, 28, 0, "c_x28");
    chk(0, KCOL, 0, 0,  0, "c_no_col_28");
    tick(0, 4);
    chk(0, KX,   0, 24, 0, "c_x24");
    chk(0, KCOL, 0, 0,  0, "col_not_yet");
    chk(0, KCOL, 0, 1,  1, "col_two_after");
    idle(1);
    repeat (3) tick(0, 4);
    chk(0, KX,   0, 24, 0, "col_freeze_x");
    chk(0, KCOL, 0, 1,  0, "col_sticky");
    pulse_clear0();
    chk(0, KCOL,  0, 0,   0, "clear_col");
    chk(0, KACTV, 0, 0,   0, "clear_active2");
    chk(0, KX,    0, 160, 0, "clear_x0");
    chk(0, KH,    0, 0,   0, "clear_h0");

    // Dino jumped high enough: no overlap even with the tallest obstacle.
    if0.dino_y = 8'd73;
    repeat (11) tick(0, 4);
    repeat (34) tick(0, 4);
    chk(0, KX,   0, 24, 0, "d_x24");
    chk(0, KCOL, 0, 0,  1, "d_no_col_a");
    chk(0, KCOL, 0, 0,  2, "d_no_col_b");
    idle(2);
    tick(0, 4);
    chk(0, KX,   0, 20, 0, "d_x20");
    chk(0, KCOL, 0, 0,  1, "d_no_col_20");
    idle(2);
    if0.dino_y = 8'd93;
    chk(0, KCOL, 0, 0, 0, "dino_move_before");
    chk(0, KCOL, 0, 1, 1, "dino_move_col");
    idle(2);
    if0.run = 1'b0;

    // Single-slot instance: gap saturates while the slot is occupied.
    if1.run = 1'b1;
    repeat (6) tick(1, 7);
    chk(1, KACTV, 0, 0, 0, "n1_no_spawn");
    tick(1, 7);
    chk(1, KACTV, 0, 1,   0, "n1_spawn");
    chk(1, KX,    0, 255, 0, "n1_spawn_x");
    chk(1, KH,    0, hexp(last_l), 0, "n1_spawn_h");
    repeat (35) tick(1, 7);
    chk(1, KX, 0, 10, 0, "n1_x10");
    tick(1, 7);
    chk(1, KX,    0, 3, 0, "n1_x3");
    chk(1, KPASS, 0, 1, 0, "n1_pass");
    tick(1, 7);
    chk(1, KACTV, 0, 0, 0, "n1_retire");
    chk(1, KPASS, 0, 0, 0, "n1_retire_pass");
    tick(1, 7);
    chk(1, KACTV, 0, 1,   0, "n1_respawn");
    chk(1, KX,    0, 255, 0, "n1_respawn_x");
    chk(1, KH,    0, hexp(last_l), 0, "n1_respawn_h");
    tick(1, 7);
    chk(1, KX, 0, 248, 0, "n1_x248");

    // Reset mid-run with a tick pending.
    if1.frame_tick = 1'b1;
    if1.speed      = 3'd7;
    reset          = 1'b1;
    @(posedge clk);
    #1;
    reset          = 1'b0;
    if1.frame_tick = 1'b0;
    chk(1, KACTV, 0, 0,   0, "midrst_active");
    chk(1, KX,    0, 255, 0, "midrst_x");
    chk(1, KH,    0, 0,   0, "midrst_h");
    chk(1, KPASS, 0, 0,   0, "midrst_pass");
    chk(0, KCOL,  0, 0,   0, "midrst_col0");
    chk(0, KACTV, 0, 0,   0, "midrst_active0");

    idle(3);
    foreach (sb[i]) begin
      total++;
      bad++;
      $display("FAIL %s: still pending at end (due cycle %0d)", sb[i].name, sb[i].cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
